// File: rtl/wshb_if.sv
// Wishbone pipelined link: master drives the request side, slave returns data and handshakes.
interface wshb_if #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADR_W      = 32
) ();

  localparam int unsigned DATA_W = 8 * DATA_BYTES;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADR_W-1:0]      adr;
  logic [DATA_W-1:0]     dat_ms;
  logic [DATA_W-1:0]     dat_sm;
  logic [DATA_BYTES-1:0] sel;
  logic [2:0]            cti;
  logic [1:0]            bte;
  logic                  ack;
  logic                  err;
  logic                  stall;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, stall
  );

endinterface

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter (VGA reader, mire writer) sharing one SDRAM link.
// A grant is held for the whole cyc of the owner; ties are round-robin or VGA-first.
module wshb_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  wshb_if.slave      wshb_ifs_vga,
  wshb_if.slave      wshb_ifs_mire,
  wshb_if.master     wshb_ifm_sdram,
  output logic [1:0] gnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_VGA  = 2'b01,
    GNT_MIRE = 2'b10
  } state_t;

  state_t state;
  logic   last_mire;
  logic   req_vga;
  logic   req_mire;
  logic   sel_vga;
  logic   sel_mire;

  assign req_vga  = wshb_ifs_vga.cyc;
  assign req_mire = wshb_ifs_mire.cyc;

  // Grant FSM; last_mire remembers who was served last for the round-robin tie-break.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      last_mire <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_vga && (!req_mire || !FAIR || last_mire)) begin
            state     <= GNT_VGA;
            gnt       <= 2'b01;
            last_mire <= 1'b0;
          end else if (req_mire) begin
            state     <= GNT_MIRE;
            gnt       <= 2'b10;
            last_mire <= 1'b1;
          end
        end
        GNT_VGA: begin
          if (!req_vga) begin
            if (req_mire) begin
              state     <= GNT_MIRE;
              gnt       <= 2'b10;
              last_mire <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        GNT_MIRE: begin
          if (!req_mire) begin
            if (req_vga) begin
              state     <= GNT_VGA;
              gnt       <= 2'b01;
              last_mire <= 1'b0;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Muxing keys off the registered grant, so an async reset blanks both sides at once.
  assign sel_vga  = gnt[0];
  assign sel_mire = gnt[1];

  assign wshb_ifm_sdram.cyc    = (sel_vga & wshb_ifs_vga.cyc) | (sel_mire & wshb_ifs_mire.cyc);
  assign wshb_ifm_sdram.stb    = (sel_vga & wshb_ifs_vga.stb) | (sel_mire & wshb_ifs_mire.stb);
  assign wshb_ifm_sdram.we     = (sel_vga & wshb_ifs_vga.we)  | (sel_mire & wshb_ifs_mire.we);
  assign wshb_ifm_sdram.adr    = sel_vga  ? wshb_ifs_vga.adr :
                                 sel_mire ? wshb_ifs_mire.adr : '0;
  assign wshb_ifm_sdram.dat_ms = sel_vga  ? wshb_ifs_vga.dat_ms :
                                 sel_mire ? wshb_ifs_mire.dat_ms : '0;
  assign wshb_ifm_sdram.sel    = sel_vga  ? wshb_ifs_vga.sel :
                                 sel_mire ? wshb_ifs_mire.sel : '0;
  assign wshb_ifm_sdram.cti    = sel_vga  ? wshb_ifs_vga.cti :
                                 sel_mire ? wshb_ifs_mire.cti : '0;
  assign wshb_ifm_sdram.bte    = sel_vga  ? wshb_ifs_vga.bte :
                                 sel_mire ? wshb_ifs_mire.bte : '0;

  // Responses reach only the owner; the loser sees a stalled, silent slave.
  assign wshb_ifs_vga.ack    = sel_vga & wshb_ifm_sdram.ack;
  assign wshb_ifs_vga.err    = sel_vga & wshb_ifm_sdram.err;
  assign wshb_ifs_vga.stall  = sel_vga ? wshb_ifm_sdram.stall : 1'b1;
  assign wshb_ifs_vga.dat_sm = wshb_ifm_sdram.dat_sm;

  assign wshb_ifs_mire.ack    = sel_mire & wshb_ifm_sdram.ack;
  assign wshb_ifs_mire.err    = sel_mire & wshb_ifm_sdram.err;
  assign wshb_ifs_mire.stall  = sel_mire ? wshb_ifm_sdram.stall : 1'b1;
  assign wshb_ifs_mire.dat_sm = wshb_ifm_sdram.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: one round-robin instance (_f) and one fixed-priority instance (_x).
module tb_wshb_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] gnt_f;
  logic [1:0] gnt_x;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         acks_seen;

  wshb_if vga_f ();
  wshb_if mire_f ();
  wshb_if sdr_f ();
  wshb_if vga_x ();
  wshb_if mire_x ();
  wshb_if sdr_x ();

  always #5 clk = ~clk;

  wshb_arbiter #(.FAIR(1'b1)) u_fair (
    .clk           (clk),
    .reset_n       (reset_n),
    .wshb_ifs_vga  (vga_f),
    .wshb_ifs_mire (mire_f),
    .wshb_ifm_sdram(sdr_f),
    .gnt           (gnt_f)
  );

  wshb_arbiter #(.FAIR(1'b0)) u_fixed (
    .clk           (clk),
    .reset_n       (reset_n),
    .wshb_ifs_vga  (vga_x),
    .wshb_ifs_mire (mire_x),
    .wshb_ifm_sdram(sdr_x),
    .gnt           (gnt_x)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    {vga_f.cyc, vga_f.stb, vga_f.we, vga_f.adr, vga_f.dat_ms, vga_f.sel, vga_f.cti, vga_f.bte} = '0;
    {mire_f.cyc, mire_f.stb, mire_f.we, mire_f.adr, mire_f.dat_ms, mire_f.sel, mire_f.cti, mire_f.bte} = '0;
    {vga_x.cyc, vga_x.stb, vga_x.we, vga_x.adr, vga_x.dat_ms, vga_x.sel, vga_x.cti, vga_x.bte} = '0;
    {mire_x.cyc, mire_x.stb, mire_x.we, mire_x.adr, mire_x.dat_ms, mire_x.sel, mire_x.cti, mire_x.bte} = '0;
    {sdr_f.ack, sdr_f.err, sdr_f.stall, sdr_f.dat_sm} = '0;
    {sdr_x.ack, sdr_x.err, sdr_x.stall, sdr_x.dat_sm} = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_gnt_f", 64'(gnt_f), 64'd0);
    chk("rst_gnt_x", 64'(gnt_x), 64'd0);
    chk("rst_sdr_cyc", 64'(sdr_f.cyc), 64'd0);
    chk("rst_vga_stall", 64'(vga_f.stall), 64'd1);

    @(negedge clk);
    reset_n = 1'b1;

    // IDLE: stray ack/err discarded, unrequested master not forwarded
    sdr_f.ack = 1'b1;
    sdr_f.err = 1'b1;
    vga_f.stb = 1'b1;
    vga_f.adr = 32'h0000_0100;
    #1;
    chk("idle_vga_ack", 64'(vga_f.ack), 64'd0);
    chk("idle_mire_ack", 64'(mire_f.ack), 64'd0);
    chk("idle_vga_err", 64'(vga_f.err), 64'd0);
    chk("idle_sdr_adr", 64'(sdr_f.adr), 64'd0);
    chk("idle_sdr_stb", 64'(sdr_f.stb), 64'd0);
    sdr_f.ack = 1'b0;
    sdr_f.err = 1'b0;

    // Tie out of reset: both instances grant VGA after one edge
    vga_f.cyc  = 1'b1;
    vga_f.sel  = 4'hf;
    mire_f.cyc = 1'b1;
    mire_f.stb = 1'b1;
    mire_f.we  = 1'b1;
    mire_f.adr = 32'h0000_0200;
    vga_x.cyc  = 1'b1;
    mire_x.cyc = 1'b1;
    tick();
    chk("tie_gnt_f", 64'(gnt_f), 64'd1);
    chk("tie_gnt_x", 64'(gnt_x), 64'd1);
    chk("vga_sdr_adr", 64'(sdr_f.adr), 64'h100);
    chk("vga_sdr_cyc", 64'(sdr_f.cyc), 64'd1);
    chk("vga_sdr_we", 64'(sdr_f.we), 64'd0);
    sdr_f.stall  = 1'b1;
    sdr_f.dat_sm = 32'hdead_beef;
    #1;
    chk("vga_stall_pass", 64'(vga_f.stall), 64'd1);
    chk("mire_datsm_bcast", 64'(mire_f.dat_sm), 64'hdead_beef);

    // Eight acks to VGA while mire waits stalled
    for (int i = 0; i < 8; i++) begin
      sdr_f.ack   = 1'b1;
      sdr_f.stall = 1'b0;
      #1;
      chk("vga_ack", 64'(vga_f.ack), 64'd1);
      chk("vga_stall_low", 64'(vga_f.stall), 64'd0);
      chk("mire_wait_stall", 64'(mire_f.stall), 64'd1);
      chk("mire_wait_ack", 64'(mire_f.ack), 64'd0);
      tick();
      chk("vga_hold_gnt", 64'(gnt_f), 64'd1);
    end
    sdr_f.ack  = 1'b0;
    vga_f.cyc  = 1'b0;
    vga_f.stb  = 1'b0;
    vga_x.cyc  = 1'b0;
    mire_x.cyc = 1'b0;
    #1;
    chk("vga_drop_sdr_cyc", 64'(sdr_f.cyc), 64'd0);
    tick();
    chk("handover_gnt_f", 64'(gnt_f), 64'd2);
    chk("handover_mire_stall", 64'(mire_f.stall), 64'd0);
    chk("handover_sdr_adr", 64'(sdr_f.adr), 64'h200);
    chk("handover_sdr_we", 64'(sdr_f.we), 64'd1);
    chk("handover_vga_stall", 64'(vga_f.stall), 64'd1);

    // Mire drops as VGA rises in the same cycle: direct handover
    mire_f.cyc = 1'b0;
    vga_f.cyc  = 1'b1;
    tick();
    chk("swap_gnt_f", 64'(gnt_f), 64'd1);
    vga_f.cyc = 1'b0;
    tick();
    chk("idle_gnt_f", 64'(gnt_f), 64'd0);

    // Second tie: round-robin picks mire (VGA served last), fixed picks VGA
    vga_f.cyc  = 1'b1;
    mire_f.cyc = 1'b1;
    vga_x.cyc  = 1'b1;
    mire_x.cyc = 1'b1;
    tick();
    chk("rr_tie_gnt_f", 64'(gnt_f), 64'd2);
    chk("fixed_tie_gnt_x", 64'(gnt_x), 64'd1);

    // Mire: four pipelined writes then four acks, VGA pending throughout
    acks_seen = 0;
    for (int i = 0; i < 8; i++) begin
      mire_f.stb = (i < 4);
      mire_f.adr = 32'h0000_0200 + 32'(4 * i);
      sdr_f.ack  = (i >= 4);
      #1;
      chk("pipe_gnt_f", 64'(gnt_f), 64'd2);
      chk("pipe_vga_ack", 64'(vga_f.ack), 64'd0);
      chk("pipe_mire_ack", 64'(mire_f.ack), 64'(i >= 4));
      if (mire_f.ack) acks_seen++;
      tick();
    end
    chk("pipe_acks_seen", 64'(acks_seen), 64'd4);
    mire_f.cyc = 1'b0;
    mire_f.stb = 1'b0;
    sdr_f.ack  = 1'b0;
    tick();
    chk("pipe_release_gnt_f", 64'(gnt_f), 64'd1);

    // Fixed priority with periodic simultaneous drops: mire never wins
    sdr_x.stall = 1'b0;
    for (int i = 0; i < 48; i++) begin
      vga_x.cyc  = ((i % 16) != 15);
      mire_x.cyc = ((i % 16) != 15);
      tick();
      if (vga_x.cyc) chk("fixed_no_mire_gnt", 64'(gnt_x == 2'b10), 64'd0);
      chk("fixed_mire_stall", 64'(mire_x.stall), 64'd1);
    end

    // Async reset mid VGA burst
    sdr_f.ack = 1'b1;
    #1;
    chk("pre_rst_sdr_cyc", 64'(sdr_f.cyc), 64'd1);
    chk("pre_rst_vga_ack", 64'(vga_f.ack), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sdr_cyc", 64'(sdr_f.cyc), 64'd0);
    chk("async_rst_gnt_f", 64'(gnt_f), 64'd0);
    chk("async_rst_vga_stall", 64'(vga_f.stall), 64'd1);
    chk("async_rst_vga_ack", 64'(vga_f.ack), 64'd0);
    chk("async_rst_sdr_adr", 64'(sdr_f.adr), 64'd0);

    @(negedge clk);
    reset_n    = 1'b1;
    sdr_f.ack  = 1'b0;
    vga_f.cyc  = 1'b0;
    mire_f.cyc = 1'b1;
    vga_x.cyc  = 1'b0;
    mire_x.cyc = 1'b1;
    tick();
    chk("post_rst_gnt_f", 64'(gnt_f), 64'd2);
    chk("post_rst_gnt_x", 64'(gnt_x), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
